// File: rtl/paged_mmu.sv
// rtl/paged_mmu.sv - TLB-backed virtual-to-physical translation with hardware page-table walk
module paged_mmu #(
    parameter int VA_W        = 16,
    parameter int PA_W        = 16,
    parameter int PAGE_BITS   = 8,
    parameter int TLB_ENTRIES = 8,
    parameter int PTE_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mmu_enable,
    input  logic [PA_W-1:0]           pt_base,
    input  logic                      tlb_flush,
    input  logic                      inv_valid,
    input  logic [VA_W-PAGE_BITS-1:0] inv_vpn,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [VA_W-1:0]           req_vaddr,
    input  logic                      req_write,
    input  logic                      req_exec,
    input  logic                      req_user,
    output logic                      rsp_valid,
    output logic [PA_W-1:0]           rsp_paddr,
    output logic [1:0]                rsp_fault,
    output logic                      pt_req,
    output logic [PA_W-1:0]           pt_addr,
    input  logic [PTE_W-1:0]          pt_rdata,
    input  logic                      pt_ack,
    output logic [15:0]               hit_count,
    output logic [15:0]               miss_count
);
    localparam int VPN_W     = VA_W - PAGE_BITS;
    localparam int PPN_W     = PA_W - PAGE_BITS;
    localparam int IDX_W     = $clog2(TLB_ENTRIES);
    localparam int PTE_BYTES = PTE_W / 8;
    localparam logic [1:0] FAULT_NONE = 2'd0;
    localparam logic [1:0] FAULT_PAGE = 2'd1;
    localparam logic [1:0] FAULT_PROT = 2'd2;

    typedef enum logic [1:0] {IDLE, LOOKUP, WALK, RESP} state_t;
    state_t state, state_next;

    logic [VA_W-1:0]      vaddr;
    logic                 acc_write, acc_exec, acc_user;
    logic [VPN_W-1:0]     vpn;
    logic [PAGE_BITS-1:0] offset;

    logic [TLB_ENTRIES-1:0] tlb_v, tlb_u, tlb_w, tlb_x;
    logic [VPN_W-1:0]       tlb_vpn [TLB_ENTRIES];
    logic [PPN_W-1:0]       tlb_ppn [TLB_ENTRIES];
    logic [IDX_W-1:0]       rr_ptr;

    logic             hit, have_invalid, walk_cancel, cancel_now, insert;
    logic [IDX_W-1:0] hit_idx, victim;
    logic [1:0]       hit_fault, walk_fault;
    logic [PA_W-1:0]  walk_addr;
    logic             unused_pte_bits;

    function automatic logic [1:0] perm_fault(input logic v, u, w, x, user, write, exec);
        if (!v)
            return FAULT_PAGE;
        if ((user && !u) || (write && !w) || (exec && !x))
            return FAULT_PROT;
        return FAULT_NONE;
    endfunction

    assign vpn             = vaddr[VA_W-1:PAGE_BITS];
    assign offset          = vaddr[PAGE_BITS-1:0];
    assign req_ready       = (state == IDLE);
    assign rsp_valid       = (state == RESP);
    assign pt_req          = (state == WALK);
    assign walk_addr       = pt_base + PA_W'(vpn) * PA_W'(PTE_BYTES);
    assign unused_pte_bits = ^pt_rdata;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (tlb_v[i] && tlb_vpn[i] == vpn) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Lowest-index free slot wins; the round-robin pointer is only the fallback.
    always_comb begin
        victim       = rr_ptr;
        have_invalid = 1'b0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!tlb_v[i]) begin
                victim       = IDX_W'(i);
                have_invalid = 1'b1;
            end
        end
    end

    assign hit_fault  = perm_fault(1'b1, tlb_u[hit_idx], tlb_w[hit_idx], tlb_x[hit_idx],
                                   acc_user, acc_write, acc_exec);
    assign walk_fault = perm_fault(pt_rdata[PTE_W-1], pt_rdata[PTE_W-2], pt_rdata[PTE_W-3],
                                   pt_rdata[PTE_W-4], acc_user, acc_write, acc_exec);
    assign cancel_now = tlb_flush || (inv_valid && inv_vpn == vpn);
    assign insert     = (state == WALK) && pt_ack && pt_rdata[PTE_W-1] && !walk_cancel && !cancel_now;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = LOOKUP;
            LOOKUP:  state_next = (!mmu_enable || hit) ? RESP : WALK;
            WALK:    if (pt_ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vaddr       <= '0;
            acc_write   <= 1'b0;
            acc_exec    <= 1'b0;
            acc_user    <= 1'b0;
            rsp_paddr   <= '0;
            rsp_fault   <= FAULT_NONE;
            pt_addr     <= '0;
            walk_cancel <= 1'b0;
            hit_count   <= '0;
            miss_count  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    vaddr     <= req_vaddr;
                    acc_write <= req_write;
                    acc_exec  <= req_exec;
                    acc_user  <= req_user;
                end
                LOOKUP: begin
                    if (!mmu_enable) begin
                        rsp_paddr <= PA_W'(vaddr);
                        rsp_fault <= FAULT_NONE;
                    end else if (hit) begin
                        rsp_fault <= hit_fault;
                        rsp_paddr <= (hit_fault == FAULT_NONE) ? {tlb_ppn[hit_idx], offset} : '0;
                        if (hit_count != 16'hFFFF)
                            hit_count <= hit_count + 16'd1;
                    end else begin
                        pt_addr     <= walk_addr;
                        walk_cancel <= 1'b0;
                        if (miss_count != 16'hFFFF)
                            miss_count <= miss_count + 16'd1;
                    end
                end
                WALK: begin
                    if (cancel_now)
                        walk_cancel <= 1'b1;
                    if (pt_ack) begin
                        rsp_fault <= walk_fault;
                        rsp_paddr <= (walk_fault == FAULT_NONE) ?
                                     {pt_rdata[PPN_W-1:0], offset} : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tlb_v  <= '0;
            rr_ptr <= '0;
        end else if (tlb_flush) begin
            tlb_v  <= '0;
            rr_ptr <= '0;
        end else begin
            if (inv_valid) begin
                for (int i = 0; i < TLB_ENTRIES; i++)
                    if (tlb_vpn[i] == inv_vpn)
                        tlb_v[i] <= 1'b0;
            end
            if (insert) begin
                tlb_v[victim] <= 1'b1;
                if (!have_invalid)
                    rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (insert) begin
            tlb_vpn[victim] <= vpn;
            tlb_ppn[victim] <= pt_rdata[PPN_W-1:0];
            tlb_u[victim]   <= pt_rdata[PTE_W-2];
            tlb_w[victim]   <= pt_rdata[PTE_W-3];
            tlb_x[victim]   <= pt_rdata[PTE_W-4];
        end
    end
endmodule

// File: tb/tb_paged_mmu.sv
// tb/tb_paged_mmu.sv - scoreboard bench for paged_mmu with a page-table memory responder
module tb_paged_mmu;
    logic        clk = 1'b0;
    logic        rst_n, mmu_enable, tlb_flush, inv_valid;
    logic [15:0] pt_base;
    logic [7:0]  inv_vpn;
    logic        req_valid, req_ready, req_write, req_exec, req_user;
    logic [15:0] req_vaddr;
    logic        rsp_valid;
    logic [15:0] rsp_paddr;
    logic [1:0]  rsp_fault;
    logic        pt_req, pt_ack, resp_ack, late_ack;
    logic [15:0] pt_addr, pt_rdata;
    logic [15:0] hit_count, miss_count;

    logic [15:0] pte_mem [256];
    logic [17:0] exp_q [$];
    logic [15:0] walk_off;
    int          ack_delay, ack_wait;
    int          n_checks = 0, n_fail = 0;
    int          exp_hits = 0, exp_misses = 0;

    paged_mmu dut (
        .clk(clk), .rst_n(rst_n), .mmu_enable(mmu_enable), .pt_base(pt_base),
        .tlb_flush(tlb_flush), .inv_valid(inv_valid), .inv_vpn(inv_vpn),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_write(req_write), .req_exec(req_exec), .req_user(req_user),
        .rsp_valid(rsp_valid), .rsp_paddr(rsp_paddr), .rsp_fault(rsp_fault),
        .pt_req(pt_req), .pt_addr(pt_addr), .pt_rdata(pt_rdata), .pt_ack(pt_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;
    assign pt_ack = resp_ack | late_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        resp_ack = 1'b0;
        pt_rdata = '0;
        ack_wait = 0;
        forever begin
            @(negedge clk);
            resp_ack = 1'b0;
            if (pt_req) begin
                if (ack_wait >= ack_delay) begin
                    walk_off = pt_addr - pt_base;
                    pt_rdata = pte_mem[walk_off[8:1]];
                    resp_ack = 1'b1;
                    ack_wait = 0;
                end else begin
                    ack_wait++;
                end
            end else begin
                ack_wait = 0;
            end
        end
    end

    task automatic access(input string tag, input logic [15:0] va, input logic wr, ex, us,
                          input logic en, exp_walk, do_flush);
        logic [15:0] pte, exp_pa;
        logic [1:0]  exp_f;
        logic [17:0] exp_rsp;
        logic        walked, got;
        logic [15:0] seen_addr;
        int          lat, walk_lat, exp_lat;
        pte = pte_mem[va[15:8]];
        if (!en)                    exp_f = 2'd0;
        else if (!pte[15])          exp_f = 2'd1;
        else if (us && !pte[14])    exp_f = 2'd2;
        else if (wr && !pte[13])    exp_f = 2'd2;
        else if (ex && !pte[12])    exp_f = 2'd2;
        else                        exp_f = 2'd0;
        exp_pa = !en ? va : (exp_f != 2'd0) ? 16'h0 : {pte[7:0], va[7:0]};
        exp_q.push_back({exp_f, exp_pa});
        if (en && exp_walk) exp_misses++;
        else if (en)        exp_hits++;
        exp_lat = exp_walk ? 3 + ack_delay : 2;

        @(posedge clk); #1;
        check({tag, ".ready"}, req_ready, 1);
        mmu_enable = en; req_vaddr = va; req_write = wr; req_exec = ex; req_user = us;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        walked = 1'b0; got = 1'b0; seen_addr = '0; walk_lat = 0; lat = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (do_flush && walked && lat == walk_lat + 1)
                tlb_flush = 1'b0;
            if (pt_req && !walked) begin
                walked = 1'b1; seen_addr = pt_addr; walk_lat = lat;
                if (do_flush) tlb_flush = 1'b1;
            end
            if (rsp_valid) begin
                got = 1'b1;
                exp_rsp = exp_q.pop_front();
                check({tag, ".paddr"}, rsp_paddr, exp_rsp[15:0]);
                check({tag, ".fault"}, rsp_fault, exp_rsp[17:16]);
            end
        end
        tlb_flush = 1'b0;
        if (!got) begin
            check({tag, ".timeout"}, 0, 1);
            void'(exp_q.pop_front());
        end
        check({tag, ".walk"}, walked, exp_walk);
        check({tag, ".latency"}, lat, exp_lat);
        if (exp_walk && walked)
            check({tag, ".pt_addr"}, seen_addr, pt_base + {7'd0, va[15:8], 1'b0});
        check({tag, ".hits"}, hit_count, exp_hits);
        check({tag, ".misses"}, miss_count, exp_misses);
    endtask

    task automatic pulse_inv(input logic [7:0] v);
        @(posedge clk); #1;
        inv_valid = 1'b1; inv_vpn = v;
        @(posedge clk); #1;
        inv_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        tlb_flush = 1'b1;
        @(posedge clk); #1;
        tlb_flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mmu_enable = 1'b0; tlb_flush = 1'b0; inv_valid = 1'b0; inv_vpn = '0;
        req_valid = 1'b0; req_vaddr = '0; req_write = 1'b0; req_exec = 1'b0; req_user = 1'b0;
        late_ack = 1'b0; pt_base = 16'h8000; ack_delay = 0;
        for (int i = 0; i < 256; i++) pte_mem[i] = 16'h0000;
        pte_mem[8'h03] = 16'hE005;
        pte_mem[8'h10] = 16'h0005;
        pte_mem[8'h11] = 16'h8005;
        pte_mem[8'h12] = 16'hC005;
        pte_mem[8'h20] = 16'hE0AB;
        pte_mem[8'h33] = 16'hE033;
        for (int i = 0; i < 9; i++) pte_mem[8'h40 + i] = 16'hE060 + 16'(i);

        repeat (3) @(negedge clk);
        check("reset.ready", req_ready, 1);
        check("reset.rsp_valid", rsp_valid, 0);
        check("reset.rsp_paddr", rsp_paddr, 0);
        check("reset.rsp_fault", rsp_fault, 0);
        check("reset.pt_req", pt_req, 0);
        check("reset.pt_addr", pt_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.hits", hit_count, 0);
        check("reset.misses", miss_count, 0);

        access("disabled", 16'h1234, 0, 0, 0, 0, 0, 0);
        access("cold_miss", 16'h0312, 0, 0, 0, 1, 1, 0);
        access("warm_hit", 16'h0312, 0, 0, 0, 1, 0, 0);

        access("pte_invalid", 16'h1020, 0, 0, 0, 1, 1, 0);
        access("pte_invalid_again", 16'h1020, 0, 0, 0, 1, 1, 0);
        access("user_fault", 16'h1144, 0, 0, 1, 1, 1, 0);
        access("write_fault", 16'h1288, 1, 0, 1, 1, 1, 0);
        access("exec_fault_hit", 16'h0312, 0, 1, 0, 1, 0, 0);
        access("user_read_hit", 16'h12FF, 0, 0, 1, 1, 0, 0);

        pulse_inv(8'h03);
        access("inv_miss", 16'h0312, 0, 0, 0, 1, 1, 0);
        access("inv_other_hit", 16'h1100, 0, 0, 0, 1, 0, 0);

        ack_delay = 5;
        access("flush_in_walk", 16'h2050, 0, 0, 0, 1, 1, 1);
        ack_delay = 0;
        access("after_flush_miss", 16'h2050, 0, 0, 0, 1, 1, 0);
        access("after_flush_other", 16'h1100, 0, 0, 0, 1, 1, 0);

        pulse_flush();
        for (int i = 0; i < 9; i++)
            access($sformatf("fill%0d", i), {8'h40 + 8'(i), 8'h0C}, 0, 0, 0, 1, 1, 0);
        access("repl_second_hits", 16'h410C, 0, 0, 0, 1, 0, 0);
        access("repl_first_misses", 16'h400C, 0, 0, 0, 1, 1, 0);

        ack_delay = 20;
        @(posedge clk); #1;
        mmu_enable = 1'b1; req_vaddr = 16'h3300; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !pt_req; i++) @(negedge clk);
        check("rst_walk.started", pt_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_walk.pt_req_async", pt_req, 0);
        check("rst_walk.pt_addr", pt_addr, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_hits = 0; exp_misses = 0; ack_delay = 0;
        @(negedge clk);
        check("rst_walk.ready", req_ready, 1);
        check("rst_walk.hits", hit_count, 0);
        check("rst_walk.misses", miss_count, 0);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        @(negedge clk);
        check("late_ack.rsp_valid", rsp_valid, 0);
        check("late_ack.ready", req_ready, 1);
        access("post_reset_miss", 16'h0312, 0, 0, 0, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/paged_mmu.md
# paged_mmu

Parametrised virtual-memory translation unit placed between the CPU load/store/fetch path and the memory system. It translates virtual addresses through a fully-associative TLB backed by a hardware page-table walker, and enforces user, write and execute permissions. It reports hit and miss statistics. Width, page size, TLB depth and PTE width are configurable, and single-entry TLB invalidation is supported.

## Interface
- VA_W, 16, virtual address width
- PA_W, 16, physical address width (PA_W ≥ PAGE_BITS+1)
- PAGE_BITS, 8, page offset width; VPN = VA_W-PAGE_BITS bits, PPN = PA_W-PAGE_BITS bits
- TLB_ENTRIES, 8, TLB entries, power of 2, ≥2
- PTE_W, 16, PTE width, multiple of 8; layout [PTE_W-1]=V, [PTE_W-2]=U, [PTE_W-3]=W, [PTE_W-4]=X, [PPN-1:0]=PPN

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- mmu_enable  in  1  0 = identity mapping
- pt_base  in  PA_W  page-table base byte address
- tlb_flush  in  1  invalidate all entries
- inv_valid / inv_vpn  in  1 / VPN  invalidate the matching entry
- req_valid, req_ready  in/out  1  request handshake
- req_vaddr  in  VA_W  virtual address
- req_write, req_exec, req_user  in  1  access type and privilege
- rsp_valid  out  1  one-cycle response pulse
- rsp_paddr  out  PA_W  translated address
- rsp_fault  out  2  0 none, 1 page fault, 2 protection
- pt_req  out  1  page-table read request, held until ack
- pt_addr  out  PA_W  PTE byte address
- pt_rdata  in  PTE_W  PTE data, valid with pt_ack
- pt_ack  in  1  read complete
- hit_count, miss_count  out  16  saturating counters

## Operation
- FSM: IDLE → LOOKUP → (RESP | WALK → RESP) → IDLE.
- req_ready = (state==IDLE). The request is registered on acceptance.
- LOOKUP: VPN is compared against all valid entries.
  - Hit → RESP, hit_count+1.
  - Miss → WALK, miss_count+1.
  - mmu_enable=0 → RESP with paddr = vaddr zero-extended or truncated to PA_W, fault 0, no counter change.
- WALK:
  - pt_req=1.
  - pt_addr = pt_base + (VPN × PTE_W/8), modulo 2^PA_W.
  - pt_addr is stable until pt_ack. On pt_ack the PTE is captured → RESP.
- TLB insertion (on walk with V=1):
  - Victim is the lowest-index invalid entry, else the round-robin pointer.
  - The pointer advances (wraps at TLB_ENTRIES-1) only when it was used.
  - PTEs with V=0 are never inserted.
- Permission check, in priority order:
  - V=0 → fault 1.
  - user & !U → fault 2.
  - write & !W → fault 2.
  - exec & !X → fault 2.
  - Otherwise fault 0.
- On any fault, rsp_paddr = 0. Otherwise rsp_paddr = {PPN, offset}.
- RESP: rsp_valid=1 for one cycle, then IDLE. There is no backpressure.
- tlb_flush clears all valid bits and resets the pointer to 0. inv_valid clears only the matching entry.
- Flush or invalidate of the same VPN in the same cycle as an insert, or at any time during the WALK that performs that insert: flush wins, no insert. The response is still delivered from the captured PTE.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - state IDLE, req_ready=1.
  - rsp_valid=0, rsp_paddr=0, rsp_fault=0.
  - pt_req=0, pt_addr=0.
  - All TLB valid bits 0, pointer 0, counters 0.
- Hit or disabled: accept at edge N, rsp_valid high in cycle N+2.
- Miss: pt_req rises in cycle N+2. If pt_ack is sampled at edge M, rsp_valid is high in cycle M+1.
  - Minimum miss latency is 3 cycles (pt_ack in the first WALK cycle).
- mmu_enable is sampled in LOOKUP.
- Protection is rechecked with the current request's req_user/req_write/req_exec on every hit.
- rst_n asserted mid-walk drops pt_req asynchronously. A late pt_ack after reset is ignored in IDLE.

## Test plan
- Disabled: mmu_enable=0, vaddr 0x1234 → rsp_paddr 0x1234, fault 0, 2-cycle latency, counters 0.
- Cold miss then hit:
  - pt_base 0x8000, vaddr 0x0312 → pt_addr 0x8006.
  - PTE 0xE005 → paddr 0x0512, miss_count 1.
  - Repeat vaddr 0x0312 → same result with no pt_req, hit_count 1.
- Faults:
  - PTE 0x0005 → fault 1, not cached; the next access walks again.
  - PTE 0x8005 with user=1 → fault 2.
  - PTE 0xC005 with write=1 → fault 2.
  - PTE 0xE005 with exec=1 → fault 2.
- Replacement: 9 distinct valid VPNs (TLB_ENTRIES=8) → the 9th evicts entry 0; the first VPN misses again, the second still hits.
- Invalidate: inv_vpn=0x03 → 0x03 misses and walks, other entries still hit. tlb_flush asserted during a WALK with pt_ack delayed 5 cycles → response correct, subsequent access misses.
- Reset mid-walk: rst_n low while pt_req=1 → pt_req=0 immediately, req_ready=1 after release, counters 0.
